frac_div_ctrl: RTL and testbench
================================

Name: frac_div_ctrl

Overview:
- Fractional-N feedback divider controller for the ADPLL. It takes the DCO clock and generates the divided feedback clock.
- Each output period is N or N+1 input cycles. A first-order (MASH-1) phase accumulator decides which, so the average ratio is N + FRAC/2^FRAC_W.
- New ratios are accepted via a valid/ready handshake into a shadow register. They apply only at output-period boundaries, so ratio changes never produce a glitch.

Parameters:
- INT_W, 8, width of the integer divide ratio.
- FRAC_W, 12, width of the fractional word and of the accumulator.
- MIN_DIV, 2, smallest legal integer ratio.
- DEFAULT_INT, 8, active integer ratio after reset.
- DEFAULT_FRAC, 0, active fractional word after reset.

Ports:
- clk_in  in  1  DCO clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  run request; level-sensitive.
- cfg_valid  in  1  new-ratio request.
- cfg_int  in  INT_W  requested integer ratio N.
- cfg_frac  in  FRAC_W  requested fractional word.
- cfg_ready  out  1  shadow register empty; a request can be taken.
- cfg_err  out  1  one-cycle pulse: request rejected.
- clk_out  out  1  divided feedback clock; registered.
- period_tick  out  1  one-cycle pulse on the first cycle of each output period.
- busy  out  1  state != IDLE.

Behaviour:
- Interface: one clock, clk_in. Reset is asynchronous and active-high on port reset.
- Reset values:
  - state=IDLE.
  - Outputs: clk_out=0, period_tick=0, cfg_err=0, cfg_ready=1, busy=0.
  - Internal: cnt=0, acc=0, active_int=DEFAULT_INT, active_frac=DEFAULT_FRAC, shadow_full=0.
- Reset mid-operation: same reset values apply. Any pending shadow configuration is discarded.
- States:
  - IDLE → RUN when enable=1.
  - RUN → DRAIN when enable=0.
  - DRAIN → RUN when enable=1; no gap, cnt keeps counting.
  - DRAIN → IDLE at the period boundary.
- Period length P = active_int + carry. {carry, acc_next} = acc + active_frac, computed in FRAC_W+1 bits. P is held in an INT_W+1-bit register and computed at each period start.
- Period start (IDLE→RUN edge, or boundary while staying in RUN):
  - cnt←0, acc←acc_next, P latched.
  - clk_out←1 and period_tick←1 on the following cycle.
- Counting: cnt increments every cycle in RUN/DRAIN.
  - Boundary = cnt==P-1.
  - clk_out←0 when cnt reaches (P>>1)-1, so clk_out is high for P>>1 cycles and low for P-(P>>1) cycles.
  - Example: P=3 gives high 1, low 2.
- IDLE: clk_out=0, cnt held at 0, acc held.
- DRAIN boundary: clk_out stays 0, no period_tick, state→IDLE.
- Config handshake:
  - Transfer when cfg_valid & cfg_ready.
  - If cfg_int ≥ MIN_DIV: shadow←{cfg_int, cfg_frac}, shadow_full←1, cfg_ready←0 on the next cycle.
  - If cfg_int < MIN_DIV: request consumed, shadow unchanged, cfg_err=1 for one cycle.
- Apply:
  - At a period boundary, or any cycle in IDLE, with shadow_full=1: active←shadow and shadow_full←0.
  - The new ratio is used for the very next period computed. acc is not cleared, for phase continuity.
- Transfer and apply in the same cycle cannot conflict, because ready implies empty. A transfer on a boundary cycle applies at the following boundary.
- cfg_frac=0: every period equals active_int exactly; carry is never 1.
- Maximum P = 2^INT_W; width is sufficient because P has INT_W+1 bits.

Decomposition:
- Shared package adpll_pkg:
  - State enum {IDLE, RUN, DRAIN}.
  - Widths INT_W and FRAC_W.
  - MIN_DIV.
- Sub-module frac_acc: the MASH-1 accumulator.
  - Inputs: clk_in, reset, step, frac.
  - Outputs: carry, acc.
- Counter, FSM and handshake live in the top level.

Test Plan:
- Default after reset, enable=1 → clk_out period 8 cycles, high 4 / low 4; period_tick every 8 cycles; busy=1.
- cfg_int=5, cfg_frac=0x800 (0.5) → after the next boundary, periods alternate 5,6,5,6… (first period 5); the mean over 100 periods is 5.5.
- Config sent mid-period (cnt=3 of 8), cfg_int=4, frac 0 → current period completes at 8; the next period is 4; cfg_ready low from the cycle after transfer until the apply boundary.
- cfg_int=1 → cfg_err pulse 1 cycle, cfg_ready stays 1, active ratio unchanged.
- enable drops at cnt=2 with P=8 → period finishes, then IDLE with clk_out=0 and busy=0. A second run re-raises enable during DRAIN → no gap, the next period starts at the boundary.
- reset asserted mid-period with a pending shadow → all outputs at reset values immediately; after release the ratio is 8 and the shadow is lost.

Source files
------------

// File: rtl/adpll_pkg.sv
// Shared widths, limits and controller state encoding for the ADPLL feedback divider.
package adpll_pkg;

    localparam int ADPLL_INT_W   = 8;
    localparam int ADPLL_FRAC_W  = 12;
    localparam int ADPLL_MIN_DIV = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/frac_acc.sv
// MASH-1 phase accumulator: carry is the overflow of acc+frac, acc advances on step.
// Latency: carry is combinational from acc/frac; acc updates on the clock after step.
// Backpressure: none; step is a single-cycle strobe.
module frac_acc
    import adpll_pkg::*;
#(
    parameter int FRAC_W = ADPLL_FRAC_W
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              step,
    input  logic [FRAC_W-1:0] frac,
    output logic              carry,
    output logic [FRAC_W-1:0] acc
);

    logic [FRAC_W:0]   sum;
    logic [FRAC_W-1:0] acc_q;
    logic [FRAC_W-1:0] acc_d;

    always_comb begin
        sum   = {1'b0, acc_q} + {1'b0, frac};
        acc_d = step ? sum[FRAC_W-1:0] : acc_q;
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign carry = sum[FRAC_W];
    assign acc   = acc_q;

endmodule

// File: rtl/frac_div_ctrl.sv
// Fractional-N feedback divider: emits periods of N or N+1 clk_in cycles, ratio swapped glitch-free.
// Latency: clk_out/period_tick rise one cycle after a period start; config applies at the next boundary.
// Backpressure: cfg_ready low while the shadow register holds an unapplied ratio.
module frac_div_ctrl
    import adpll_pkg::*;
#(
    parameter int INT_W        = ADPLL_INT_W,
    parameter int FRAC_W       = ADPLL_FRAC_W,
    parameter int MIN_DIV      = ADPLL_MIN_DIV,
    parameter int DEFAULT_INT  = 8,
    parameter int DEFAULT_FRAC = 0
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              enable,
    input  logic              cfg_valid,
    input  logic [INT_W-1:0]  cfg_int,
    input  logic [FRAC_W-1:0] cfg_frac,
    output logic              cfg_ready,
    output logic              cfg_err,
    output logic              clk_out,
    output logic              period_tick,
    output logic              busy
);

    localparam logic [INT_W-1:0]  DEF_INT   = DEFAULT_INT[INT_W-1:0];
    localparam logic [FRAC_W-1:0] DEF_FRAC  = DEFAULT_FRAC[FRAC_W-1:0];
    localparam logic [INT_W-1:0]  MIN_DIV_V = MIN_DIV[INT_W-1:0];
    localparam logic [INT_W:0]    ONE       = {{INT_W{1'b0}}, 1'b1};

    state_e             state_q, state_d;
    logic [INT_W:0]     cnt_q, cnt_d;
    logic [INT_W:0]     p_q, p_d;
    logic               clk_out_q, clk_out_d;
    logic               tick_q, tick_d;
    logic               err_q, err_d;
    logic [INT_W-1:0]   active_int_q, active_int_d;
    logic [FRAC_W-1:0]  active_frac_q, active_frac_d;
    logic [INT_W-1:0]   shadow_int_q, shadow_int_d;
    logic [FRAC_W-1:0]  shadow_frac_q, shadow_frac_d;
    logic               shadow_full_q, shadow_full_d;

    logic               running;
    logic               boundary;
    logic               apply;
    logic               period_start;
    logic               cfg_xfer;
    logic               cfg_ok;
    logic [INT_W-1:0]   eff_int;
    logic [FRAC_W-1:0]  eff_frac;
    logic               carry;
    logic [FRAC_W-1:0]  acc_unused;

    frac_acc #(
        .FRAC_W (FRAC_W)
    ) u_frac_acc (
        .clk_in (clk_in),
        .reset  (reset),
        .step   (period_start),
        .frac   (eff_frac),
        .carry  (carry),
        .acc    (acc_unused)
    );

    always_comb begin
        running      = (state_q != IDLE);
        boundary     = running && (cnt_q == (p_q - ONE));
        apply        = shadow_full_q && (boundary || !running);
        // A ratio applied this cycle already shapes the period being launched now.
        eff_int      = apply ? shadow_int_q  : active_int_q;
        eff_frac     = apply ? shadow_frac_q : active_frac_q;
        period_start = enable && (boundary || !running);
        cfg_xfer     = cfg_valid && !shadow_full_q;
        cfg_ok       = (cfg_int >= MIN_DIV_V);

        state_d = state_q;
        unique case (state_q)
            IDLE:       if (enable) state_d = RUN;
            RUN, DRAIN: begin
                if (boundary && !enable) state_d = IDLE;
                else                     state_d = enable ? RUN : DRAIN;
            end
            default:    state_d = IDLE;
        endcase

        cnt_d = (period_start || boundary || !running) ? '0 : cnt_q + ONE;
        p_d   = period_start ? ({1'b0, eff_int} + {{INT_W{1'b0}}, carry}) : p_q;

        if (period_start) begin
            clk_out_d = 1'b1;
        end else if (!running || boundary || (cnt_q == ((p_q >> 1) - ONE))) begin
            clk_out_d = 1'b0;
        end else begin
            clk_out_d = clk_out_q;
        end

        tick_d = period_start;
        err_d  = cfg_xfer && !cfg_ok;

        shadow_int_d  = shadow_int_q;
        shadow_frac_d = shadow_frac_q;
        shadow_full_d = shadow_full_q;
        if (cfg_xfer && cfg_ok) begin
            shadow_int_d  = cfg_int;
            shadow_frac_d = cfg_frac;
            shadow_full_d = 1'b1;
        end else if (apply) begin
            shadow_full_d = 1'b0;
        end

        active_int_d  = eff_int;
        active_frac_d = eff_frac;
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            p_q           <= {1'b0, DEF_INT};
            clk_out_q     <= 1'b0;
            tick_q        <= 1'b0;
            err_q         <= 1'b0;
            active_int_q  <= DEF_INT;
            active_frac_q <= DEF_FRAC;
            shadow_int_q  <= '0;
            shadow_frac_q <= '0;
            shadow_full_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            p_q           <= p_d;
            clk_out_q     <= clk_out_d;
            tick_q        <= tick_d;
            err_q         <= err_d;
            active_int_q  <= active_int_d;
            active_frac_q <= active_frac_d;
            shadow_int_q  <= shadow_int_d;
            shadow_frac_q <= shadow_frac_d;
            shadow_full_q <= shadow_full_d;
        end
    end

    assign cfg_ready   = !shadow_full_q;
    assign cfg_err     = err_q;
    assign clk_out     = clk_out_q;
    assign period_tick = tick_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_frac_div_ctrl.sv
// Randomized bench for frac_div_ctrl: driver logs accepted requests, monitor checks every cycle
// against a period-level model (running period length/position plus a phase accumulator).
module tb_frac_div_ctrl;

    logic        clk_in;
    logic        reset;
    logic        enable;
    logic        cfg_valid;
    logic [7:0]  cfg_int;
    logic [11:0] cfg_frac;
    logic        cfg_ready;
    logic        cfg_err;
    logic        clk_out;
    logic        period_tick;
    logic        busy;

    frac_div_ctrl dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .enable      (enable),
        .cfg_valid   (cfg_valid),
        .cfg_int     (cfg_int),
        .cfg_frac    (cfg_frac),
        .cfg_ready   (cfg_ready),
        .cfg_err     (cfg_err),
        .clk_out     (clk_out),
        .period_tick (period_tick),
        .busy        (busy)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    typedef struct {
        int t;
        int n;
        int f;
        bit ok;
    } xfer_t;

    xfer_t xq[$];
    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, got, want);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s cyc=%0d (bound expired)", name, cyc);
    endtask

    // Reference model: a period is either running (length, position) or not.
    int m_in, m_pos, m_plen, m_acc, m_act_n, m_act_f, m_pend, m_pn, m_pf;
    bit m_exp_err, m_last, m_carry;
    xfer_t mx;

    always @(negedge clk_in) begin
        if (reset) begin
            m_in = 0; m_pos = 0; m_plen = 0; m_acc = 0;
            m_act_n = 8; m_act_f = 0; m_pend = 0; m_pn = 0; m_pf = 0;
            xq.delete();
        end else begin
            m_exp_err = 1'b0;
            while (xq.size() > 0 && xq[0].t < cyc) begin
                mx = xq.pop_front();
                if (mx.ok) begin
                    m_pend = 1; m_pn = mx.n; m_pf = mx.f;
                end else begin
                    m_exp_err = 1'b1;
                end
            end
            chk("clk_out",     int'(clk_out),     (m_in != 0 && m_pos < m_plen / 2) ? 1 : 0);
            chk("period_tick", int'(period_tick), (m_in != 0 && m_pos == 0) ? 1 : 0);
            chk("busy",        int'(busy),        m_in);
            chk("cfg_ready",   int'(cfg_ready),   (m_pend != 0) ? 0 : 1);
            chk("cfg_err",     int'(cfg_err),     int'(m_exp_err));

            m_last = (m_in != 0) && (m_pos == m_plen - 1);
            if (m_pend != 0 && (m_last || m_in == 0)) begin
                m_act_n = m_pn; m_act_f = m_pf; m_pend = 0;
            end
            if (enable && (m_in == 0 || m_last)) begin
                m_acc   = m_acc + m_act_f;
                m_carry = (m_acc >= 4096);
                if (m_carry) m_acc = m_acc - 4096;
                m_plen  = m_act_n + int'(m_carry);
                m_pos   = 0;
                m_in    = 1;
            end else if (m_last) begin
                m_in = 0;
            end else if (m_in != 0) begin
                m_pos++;
            end
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic log_xfer(input int n, input int f);
        xfer_t x;
        x.t  = cyc;
        x.n  = n;
        x.f  = f;
        x.ok = (n >= 2);
        xq.push_back(x);
    endtask

    task automatic send_cfg(input int n, input int f);
        int guard;
        guard = 0;
        while (!cfg_ready && guard < 1000) begin
            step();
            guard++;
        end
        if (!cfg_ready) fail_now("cfg_ready_wait");
        cfg_valid = 1'b1;
        cfg_int   = n[7:0];
        cfg_frac  = f[11:0];
        if (cfg_ready) log_xfer(n, f);
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic wait_tick();
        int guard;
        guard = 0;
        while (!period_tick && guard < 600) begin
            step();
            guard++;
        end
        if (!period_tick) fail_now("wait_tick");
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_clk_out"},     int'(clk_out),     0);
        chk({tag, "_period_tick"}, int'(period_tick), 0);
        chk({tag, "_cfg_err"},     int'(cfg_err),     0);
        chk({tag, "_cfg_ready"},   int'(cfg_ready),   1);
        chk({tag, "_busy"},        int'(busy),        0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1, nt, guard, n, f;
        reset     = 1'b1;
        enable    = 1'b0;
        cfg_valid = 1'b0;
        cfg_int   = '0;
        cfg_frac  = '0;
        #3;
        chk_reset_outputs("rst");
        repeat (3) step();
        reset = 1'b0;
        repeat (2) step();

        // default ratio 8 with 4/4 duty
        enable = 1'b1;
        repeat (30) step();

        // mid-period ratio change: period in flight finishes at 8, next is 4
        wait_tick();
        repeat (3) step();
        send_cfg(4, 0);
        repeat (24) step();
        send_cfg(8, 0);
        repeat (20) step();

        // 5 + 0.5: alternating 5,6 from an accumulator at zero
        send_cfg(5, 12'h800);
        guard = 0;
        while (!cfg_ready && guard < 50) begin step(); guard++; end
        chk("tick_at_apply", int'(period_tick), 1);
        c0 = cyc;
        nt = 0;
        guard = 0;
        while (nt < 100 && guard < 2000) begin
            step();
            guard++;
            if (period_tick) nt++;
        end
        c1 = cyc;
        chk("cycles_100_periods", c1 - c0, 550);

        // rejected request
        send_cfg(1, 12'h123);
        repeat (10) step();
        send_cfg(0, 12'h000);
        repeat (10) step();
        send_cfg(8, 0);
        repeat (20) step();

        // drain to idle, then re-raise enable inside a drain
        wait_tick();
        repeat (2) step();
        enable = 1'b0;
        repeat (20) step();
        enable = 1'b1;
        wait_tick();
        step();
        enable = 1'b0;
        repeat (2) step();
        enable = 1'b1;
        repeat (30) step();

        // largest and smallest periods
        send_cfg(255, 12'hFFF);
        repeat (800) step();
        send_cfg(2, 12'hFFF);
        repeat (40) step();
        send_cfg(2, 0);
        repeat (20) step();

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) enable = ~enable;
            cfg_valid = ($urandom_range(0, 5) == 0);
            n = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(2, 12));
            case ($urandom_range(0, 3))
                0:       f = 0;
                1:       f = 12'hFFF;
                default: f = int'($urandom_range(0, 4095));
            endcase
            cfg_int  = n[7:0];
            cfg_frac = f[11:0];
            if (cfg_valid && cfg_ready) log_xfer(n, f);
            step();
        end
        cfg_valid = 1'b0;

        // reset with a pending shadow: the shadow must be lost
        enable = 1'b1;
        repeat (30) step();
        send_cfg(12, 0);
        chk("ready_low_pending", int'(cfg_ready), 0);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        step();
        step();
        reset = 1'b0;
        repeat (50) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
